// File: rtl/serial_cmp_fsm.sv
// serial_cmp_fsm
//   Bit-serial magnitude comparator back end. It consumes one set of per-bit
//   flags (eq/big/sma) from the 1-bit comparator cell per valid cycle, MSB
//   first, and folds WIDTH of them into one eq/neq/big/sma verdict. The
//   comparison runs under a start/done handshake.
//
//   Build option: define CMP_EARLY_EXIT_EN to finish the comparison on the
//   first bit that decides BIG or SMA. When it is undefined, exactly WIDTH
//   bits are always consumed.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a comparison (accepted in IDLE only)
//   bit_valid  in   eq_in/big_in/sma_in valid this cycle
//   eq_in      in   per-bit a==b
//   big_in     in   per-bit a>b
//   sma_in     in   per-bit a<b
//   busy       out  comparison in progress
//   done       out  one-cycle pulse, result valid
//   eq/neq     out  operands equal / differ
//   big/sma    out  A > B / A < B
//   err        out  illegal flag combination seen in this comparison
//
// state | meaning
// IDLE  | waiting for start, result outputs hold the last verdict
// RUN   | consuming bit flags, stalls while bit_valid is low
// DONE  | one-cycle done pulse, result registered on entry

module serial_cmp_fsm #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic eq_in,
  input  logic big_in,
  input  logic sma_in,
  output logic busy,
  output logic done,
  output logic eq,
  output logic neq,
  output logic big,
  output logic sma,
  output logic err
);

`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {V_EQ, V_BIG, V_SMA} verdict_t;

  state_t           state_q, state_d;
  verdict_t         verdict_q, verdict_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             eq_q, eq_d, neq_q, neq_d, big_q, big_d, sma_q, sma_d;
  logic             legal;
  logic             decided;

  // Exactly one flag high is the only legal encoding from the comparator cell.
  assign legal = $onehot({eq_in, big_in, sma_in});

  always_comb begin
    state_d   = state_q;
    verdict_d = verdict_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    eq_d      = eq_q;
    neq_d     = neq_q;
    big_d     = big_q;
    sma_d     = sma_q;
    decided   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          verdict_d = V_EQ;
          err_d     = 1'b0;
        end
      end
      S_RUN: begin
        if (bit_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!legal) begin
            // An illegal bit still counts but never moves the verdict.
            err_d = 1'b1;
          end else if (verdict_q == V_EQ) begin
            if (big_in) begin
              verdict_d = V_BIG;
              decided   = 1'b1;
            end else if (sma_in) begin
              verdict_d = V_SMA;
              decided   = 1'b1;
            end
          end
          if (cnt_q == LAST_BIT || (EARLY_EXIT && decided)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Load the result on the RUN->DONE edge so it is valid alongside done,
    // including the verdict contributed by the final bit.
    if (state_q == S_RUN && state_d == S_DONE) begin
      eq_d  = (verdict_d == V_EQ);
      neq_d = (verdict_d != V_EQ);
      big_d = (verdict_d == V_BIG);
      sma_d = (verdict_d == V_SMA);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      verdict_q <= V_EQ;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      eq_q      <= 1'b0;
      neq_q     <= 1'b0;
      big_q     <= 1'b0;
      sma_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      verdict_q <= verdict_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      eq_q      <= eq_d;
      neq_q     <= neq_d;
      big_q     <= big_d;
      sma_q     <= sma_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign eq   = eq_q;
  assign neq  = neq_q;
  assign big  = big_q;
  assign sma  = sma_q;
  assign err  = err_q;

endmodule

// File: tb/tb_serial_cmp_fsm.sv
// Testbench for serial_cmp_fsm (WIDTH=4). Expected verdicts are pushed to a
// scoreboard queue when a comparison is launched and popped by a monitor
// whenever the DUT pulses done.

module tb_serial_cmp_fsm;

  localparam int WIDTH = 4;
`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // per-bit flag encodings {eq_in, big_in, sma_in}
  localparam logic [2:0] F_EQ  = 3'b100;
  localparam logic [2:0] F_BIG = 3'b010;
  localparam logic [2:0] F_SMA = 3'b001;
  localparam logic [2:0] F_ILL = 3'b110;

  logic clk, rst_n, start, bit_valid, eq_in, big_in, sma_in;
  logic busy, done, eq, neq, big, sma, err;

  int n_chk  = 0;
  int n_fail = 0;
  logic [4:0] sb_q[$];
  logic [3:0] prev_res;

  serial_cmp_fsm #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
    .eq_in(eq_in), .big_in(big_in), .sma_in(sma_in),
    .busy(busy), .done(done), .eq(eq), .neq(neq), .big(big), .sma(sma),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_done", 1, 0);
      end else begin
        check_val("result_eq_neq_big_sma_err", {eq, neq, big, sma, err}, sb_q.pop_front());
      end
    end
  end

  // Reference: MSB-first, first legal differing bit decides, illegal bits only set err.
  function automatic logic [4:0] model(input logic [11:0] f, output int n);
    logic [1:0] v;
    logic e;
    logic [2:0] b;
    v = 2'd0;
    e = 1'b0;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      b = f[11-3*i -: 3];
      n++;
      if (!$onehot(b)) e = 1'b1;
      else if (v == 2'd0) begin
        if (b[1]) v = 2'd1;
        else if (b[0]) v = 2'd2;
        if (EARLY && v != 2'd0) break;
      end
    end
    return {v == 2'd0, v != 2'd0, v == 2'd1, v == 2'd2, e};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmp(input string tag, input logic [11:0] flags, input int stall_at,
                         input int n_stall, input logic [4:0] exp_res, input int exp_done,
                         input bit poke_run_start, input bit poke_done_start);
    int cyc, idx, stalls_left, done_cyc;
    sb_q.push_back(exp_res);
    start = 1'b1;
    bit_valid = 1'b0;
    step();
    start = 1'b0;
    cyc = 1;
    idx = 0;
    stalls_left = n_stall;
    done_cyc = -1;
    check_val({tag, "_hold_on_start"}, {eq, neq, big, sma}, prev_res);
    check_val({tag, "_err_clear"}, err, 0);
    while (cyc < 40) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      check_val({tag, "_busy_run"}, busy, 1);
      start = (poke_run_start && cyc == 2);
      if (idx == stall_at && stalls_left > 0) begin
        bit_valid = 1'b0;
        stalls_left--;
      end else if (idx < WIDTH) begin
        bit_valid = 1'b1;
        {eq_in, big_in, sma_in} = flags[11-3*idx -: 3];
        idx++;
      end else begin
        bit_valid = 1'b0;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    bit_valid = 1'b0;
    check_val({tag, "_done_cycle"}, done_cyc, exp_done);
    check_val({tag, "_busy_in_done"}, busy, 0);
    start = poke_done_start;
    step();
    start = 1'b0;
    check_val({tag, "_done_one_cycle"}, {done, busy}, 2'b00);
    check_val({tag, "_result_held"}, {eq, neq, big, sma}, exp_res[4:1]);
    prev_res = exp_res[4:1];
    step();
  endtask

  initial begin
    logic [4:0] r;
    logic [11:0] f;
    logic [2:0] fb;
    int n, sat, nst, ed;

    rst_n = 1'b0;
    start = 1'b0;
    bit_valid = 1'b0;
    {eq_in, big_in, sma_in} = 3'b000;
    prev_res = 4'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", {busy, done, eq, neq, big, sma, err}, 7'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_cmp("equal", {F_EQ, F_EQ, F_EQ, F_EQ}, 9, 0, 5'b10000, 5, 1'b1, 1'b0);
    run_cmp("a1010_b1001", {F_EQ, F_EQ, F_BIG, F_SMA}, 9, 0, 5'b01100, EARLY ? 4 : 5, 1'b0, 1'b0);
    run_cmp("stall_sma", {F_SMA, F_BIG, F_BIG, F_EQ}, 2, 2, 5'b01010, EARLY ? 2 : 7, 1'b0, 1'b1);
    run_cmp("msb_big", {F_BIG, F_SMA, F_EQ, F_EQ}, 9, 0, 5'b01100, EARLY ? 2 : 5, 1'b0, 1'b0);
    run_cmp("illegal", {F_EQ, F_EQ, F_ILL, F_EQ}, 9, 0, 5'b10001, 5, 1'b0, 1'b0);
    run_cmp("after_illegal", {F_EQ, F_EQ, F_EQ, F_EQ}, 9, 0, 5'b10000, 5, 1'b0, 1'b0);

    // Reset in the middle of a comparison: outputs clear, no done follows.
    start = 1'b1;
    step();
    start = 1'b0;
    bit_valid = 1'b1;
    {eq_in, big_in, sma_in} = F_EQ;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_val("reset_mid_run", {busy, done, eq, neq, big, sma, err}, 7'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_val("idle_after_reset", {busy, done}, 2'b00);
    end
    bit_valid = 1'b0;
    prev_res = 4'b0;

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ($urandom_range(0, 7))
          0: fb = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
          1, 2: fb = F_BIG;
          3, 4: fb = F_SMA;
          default: fb = F_EQ;
        endcase
        f[11-3*i -: 3] = fb;
      end
      sat = $urandom_range(0, WIDTH - 1);
      nst = $urandom_range(0, 2);
      r = model(f, n);
      ed = 1 + n + ((sat < n) ? nst : 0);
      run_cmp("random", f, sat, nst, r, ed, 1'b0, 1'b0);
    end

    repeat (3) step();
    check_val("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_cmp_fsm.md
Name: serial_cmp_fsm

Overview:
- Sequential consumer of the per-bit comparator flags (eq/big/sma) produced by the team's 1-bit comparator cell.
- Upstream presents one operand bit-pair per cycle, MSB first. This block folds WIDTH bit results into a single multi-bit magnitude verdict (eq/neq/big/sma) with a start/done handshake.
- Sits directly downstream of the 1-bit comparator, forming a bit-serial WIDTH-bit comparator.

Parameters:
WIDTH, 4, number of bit results per comparison (>=2)
CNT_W, $clog2(WIDTH), bit-count register width (derived, do not override)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins a new comparison (accepted only in IDLE)
bit_valid  input  1  eq_in/big_in/sma_in valid this cycle
eq_in  input  1  per-bit flag: a==b
big_in  input  1  per-bit flag: a>b
sma_in  input  1  per-bit flag: a<b
busy  output  1  high in RUN
done  output  1  one-cycle pulse; result valid
eq  output  1  WIDTH-bit operands equal
neq  output  1  operands differ (always ~eq once done has fired)
big  output  1  operand A > operand B
sma  output  1  operand A < operand B
err  output  1  illegal flag combination seen in this comparison

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset (async assert, sync release): state=IDLE; cnt=0; internal verdict=EQ. Outputs: busy=0, done=0, eq=0, neq=0, big=0, sma=0, err=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN next cycle; cnt<=0; verdict<=EQ; err<=0.
  - bit_valid ignored in IDLE.
  - eq/neq/big/sma hold the last result.
- RUN:
  - busy=1. Each cycle with bit_valid=1 consumes one bit; bit_valid=0 cycles are stalls, and nothing changes.
  - Verdict update applies only while verdict==EQ (MSB-first; first differing bit decides):
    - big_in=1 -> BIG.
    - sma_in=1 -> SMA.
    - Once BIG/SMA is set, later bits do not change it.
  - Legal input: exactly one of eq_in/big_in/sma_in high.
  - Illegal input (zero or more than one high):
    - err<=1, sticky until next accepted start.
    - The bit still counts but does not affect the verdict.
  - cnt increments per consumed bit. Consuming bit with cnt==WIDTH-1 -> DONE next cycle.
  - start during RUN is ignored; no restart.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - eq/neq/big/sma registered from the final verdict. Exactly one of eq/big/sma is 1; neq=~eq.
  - Next state IDLE unconditionally.
  - start asserted during DONE is ignored (must be re-pulsed in IDLE).
- Latency: start at cycle 0 -> first bit consumable at cycle 1. With no stalls, done at cycle WIDTH+1.
- Result outputs stay stable from done until the next DONE. They do not clear on start.
- Reset mid-RUN: immediate return to reset values. The partial comparison is discarded; no done pulse.

Optional Feature:
- Macro: CMP_EARLY_EXIT_EN.
- Defined: in RUN, the first consumed bit that sets the verdict to BIG or SMA ends the comparison.
  - DONE follows next cycle, with the same done/result semantics as above.
  - Remaining upstream bits are ignored (IDLE ignores bit_valid).
  - err reflects only bits consumed up to that point.
- Undefined: always consumes exactly WIDTH bits before DONE.

Test Plan:
- Reset check: assert rst_n=0 mid-RUN after 2 bits -> all outputs 0 immediately; state IDLE; no done pulse after release.
- Equal operands, WIDTH=4: start; 4 cycles eq_in=1 -> done at cycle 5 with eq=1, neq=0, big=0, sma=0, err=0.
- A=1010, B=1001: per-bit flags eq,eq,big,sma -> big=1, neq=1, sma=0, eq=0. A later sma bit must not flip the result.
- Stalls: A=0110, B=1000 with bit_valid low 2 cycles between bits 1 and 2 -> sma=1. done at cycle 7; busy high cycles 1-6.
- Illegal flags: bit 2 has eq_in=1 and big_in=1, all others eq -> err=1, eq=1 at done. Next start clears err to 0.
- With CMP_EARLY_EXIT_EN: MSB flag big_in=1 -> done at cycle 2, big=1. Start during DONE ignored; start in IDLE accepted.
